apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB requester: turns single-beat commands from a local valid/ready port into APB
//  SETUP/ACCESS transfers on one PSEL line and returns one response per command.
//  Sits between the test/control logic and APB slave peripherals (e.g. the
//  DATA/CONTROL/RESULT accumulator). Handles wait states, PSLVERR and a no-PREADY timeout.
// PARAMETERS
//  ADDR_W       8   PADDR / cmd_addr width
//  DATA_W       32  PWDATA / PRDATA / cmd_wdata / rsp_rdata width
//  TIMEOUT_CYC  16  max ACCESS cycles without PREADY before abort (>=1)
// PORTS
//  PCLK         in   1       clock, all logic on rising edge
//  PRESETn      in   1       asynchronous active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       bridge accepts command this cycle
//  cmd_write    in   1       1=write, 0=read
//  cmd_addr     in   ADDR_W  target address
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       one-cycle response pulse
//  rsp_rdata    out  DATA_W  read data (0 for writes, timeouts)
//  rsp_err      out  1       PSLVERR seen or timeout
//  rsp_timeout  out  1       transfer aborted by timeout
//  PSEL         out  1       APB select
//  PENABLE      out  1       APB enable
//  PWRITE       out  1       APB direction
//  PADDR        out  ADDR_W  APB address
//  PWDATA       out  DATA_W  APB write data
//  PRDATA       in   DATA_W  APB read data
//  PREADY       in   1       APB ready
//  PSLVERR      in   1       APB error, valid with PREADY
// BEHAVIOUR
//  - All outputs registered. Reset (PRESETn=0, any time): state=IDLE, every output 0,
//    timeout counter 0; an in-flight transfer is dropped with no response.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE.
//    IDLE: cmd_ready=1, PSEL=0, PENABLE=0. cmd_valid&&cmd_ready latches cmd_write/
//      cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, sets PSEL=1, goes SETUP.
//    SETUP: exactly one cycle, PSEL=1, PENABLE=0; next cycle PENABLE=1, go ACCESS.
//    ACCESS: PSEL=PENABLE=1, PADDR/PWDATA/PWRITE stable. On edge with PREADY=1:
//      PSEL=PENABLE=0, rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0,
//      rsp_rdata = (!PWRITE) ? PRDATA : 0; go IDLE.
//  - cmd_ready=0 in SETUP/ACCESS; cmd_valid there is ignored (not latched).
//  - Timeout: counter clears entering ACCESS, +1 per ACCESS cycle with PREADY=0.
//    When it reaches TIMEOUT_CYC: abort, PSEL=PENABLE=0, rsp_valid=1, rsp_err=1,
//    rsp_timeout=1, rsp_rdata=0, go IDLE. PREADY=1 on the same edge wins (normal done).
//  - PREADY/PSLVERR/PRDATA outside ACCESS are ignored.
//  - rsp_valid high exactly one cycle; no response backpressure; rsp_rdata/rsp_err/
//    rsp_timeout hold until next response.
//  - After completion PADDR/PWRITE/PWDATA keep last values in IDLE.
//  - Latency: cmd accepted edge N -> SETUP cycle N+1 -> ACCESS N+2; zero-wait slave
//    gives rsp_valid in N+3; each wait state adds one cycle. Next accept earliest N+3
//    (back-to-back throughput 3 cycles/transfer, zero wait).
// TESTING
//  1 Zero-wait model: write 0x04 <- 0xA5A5_0001 -> PSEL 1 cycle w/o PENABLE, 1 ACCESS
//    cycle, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
//  2 With accumulator slave (1 wait): write 0x00<-0x0000_00F0, write 0x04<-0x1,
//    read 0x08 -> rsp_rdata=0x0000_00F0, rsp_err=0; read 0x04 -> 0x0000_0001.
//  3 Error: write 0x08 <- 0x1234 to accumulator -> rsp_err=1, rsp_timeout=0; read 0x0C
//    -> rsp_err=1, rsp_rdata=0.
//  4 Timeout: PREADY tied 0, TIMEOUT_CYC=16 -> 16 ACCESS cycles, then rsp_valid,
//    rsp_err=1, rsp_timeout=1, PSEL=0; PREADY=1 on cycle 16 -> normal completion.
//  5 Wait states 0..5 randomized, PADDR/PWDATA checked stable through ACCESS;
//    cmd_valid pulsed during ACCESS never starts an extra transfer.
//  6 PRESETn low during ACCESS -> all outputs 0 next, no rsp_valid; after release a
//    new read 0x00 completes with correct data.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Local command/response port plus APB requester signals for apb_master_bridge.
// master = bridge side, slave = environment (command source and APB peripheral).
interface apb_master_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one local command -> one SETUP/ACCESS transfer -> one response.
// Handles wait states, PSLVERR and an ACCESS-phase timeout when PREADY never rises.
module apb_master_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_master_bridge_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q is the registered handshake the requester sees
        if (bus.cmd_valid && cmd_ready_q) begin
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: accumulator-style APB peripheral, transfer-level
// reference model compared every cycle, plus directed literal expectations.
module tb_apb_master_bridge;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK(clk), .PRESETn(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int wait_plan = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  // peripheral map: 0x00 DATA, 0x04 CONTROL (bit0 adds DATA into RESULT),
  // 0x08 RESULT read-only; anything else errors
  function automatic logic p_err(input logic [7:0] a, input logic w);
    return !(a == 8'h00 || a == 8'h04 || a == 8'h08) || (w && a == 8'h08);
  endfunction

  function automatic logic [31:0] p_rd(input logic [7:0] a,
      input logic [31:0] d, input logic [31:0] c, input logic [31:0] r);
    return (a == 8'h00) ? d : (a == 8'h04) ? c : (a == 8'h08) ? r : 32'h0;
  endfunction

  // APB peripheral: PREADY after wait_plan ACCESS cycles, junk outside ACCESS
  logic [31:0] s_data = 0, s_ctrl = 0, s_res = 0;
  int acnt = 0;
  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE) begin
      bus.PREADY = (acnt == wait_plan);
      acnt++;
      bus.PSLVERR = p_err(bus.PADDR, bus.PWRITE);
      if (bus.PWRITE)
        bus.PRDATA = 32'hBAD0_0000;
      else if (bus.PSLVERR)
        bus.PRDATA = 32'h0;
      else
        bus.PRDATA = p_rd(bus.PADDR, s_data, s_ctrl, s_res);
      if (bus.PREADY && bus.PWRITE && !bus.PSLVERR) begin
        if (bus.PADDR == 8'h00) s_data = bus.PWDATA;
        if (bus.PADDR == 8'h04) begin
          s_ctrl = bus.PWDATA;
          if (bus.PWDATA[0]) s_res = s_res + s_data;
        end
      end
    end else begin
      acnt = 0;
      bus.PREADY = 1'b1;
      bus.PSLVERR = 1'b1;
      bus.PRDATA = 32'hDEAD_BEEF;
    end
  end

  // transfer-level reference: accept at edge S, wait w -> response edge
  // S+2+min(w,TO-1); address phase outputs derived from edge distance to S
  int ecnt = 0, s_edge = 0, e_edge = 0;
  bit busy = 0, m_tmo = 0;
  logic m_ready = 0, m_psel = 0, m_pen = 0, m_pwrite = 0;
  logic [7:0] m_paddr = 0;
  logic [31:0] m_pwdata = 0, m_rdata = 0;
  logic m_rv = 0, m_err = 0, m_to = 0;
  logic [31:0] m_data = 0, m_ctrl = 0, m_res = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; m_ready = 0; m_psel = 0; m_pen = 0; m_pwrite = 0;
      m_paddr = 0; m_pwdata = 0; m_rv = 0; m_rdata = 0;
      m_err = 0; m_to = 0;
    end else begin
      ecnt++;
      m_rv = 0;
      if (busy) begin
        if (ecnt == e_edge) begin
          busy = 0; m_psel = 0; m_pen = 0; m_ready = 1; m_rv = 1;
          if (m_tmo) begin
            m_err = 1; m_to = 1; m_rdata = 0;
          end else begin
            m_to = 0;
            m_err = p_err(m_paddr, m_pwrite);
            m_rdata = (m_pwrite || m_err) ? 32'h0 :
                      p_rd(m_paddr, m_data, m_ctrl, m_res);
            if (m_pwrite && !m_err && m_paddr == 8'h00) m_data = m_pwdata;
            if (m_pwrite && !m_err && m_paddr == 8'h04) begin
              m_ctrl = m_pwdata;
              if (m_pwdata[0]) m_res = m_res + m_data;
            end
          end
        end else begin
          m_pen = (ecnt > s_edge);
        end
      end else if (m_ready && bus.cmd_valid) begin
        busy = 1; s_edge = ecnt; m_ready = 0;
        m_psel = 1; m_pen = 0;
        m_pwrite = bus.cmd_write; m_paddr = bus.cmd_addr;
        m_pwdata = bus.cmd_wdata;
        m_tmo = (wait_plan >= TO);
        e_edge = s_edge + 2 + (m_tmo ? TO - 1 : wait_plan);
      end else begin
        m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", bus.cmd_ready, m_ready);
    chk("PSEL", bus.PSEL, m_psel);
    chk("PENABLE", bus.PENABLE, m_pen);
    chk("PWRITE", bus.PWRITE, m_pwrite);
    chk("PADDR", bus.PADDR, m_paddr);
    chk("PWDATA", bus.PWDATA, m_pwdata);
    chk("rsp_valid", bus.rsp_valid, m_rv);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    chk("rsp_err", bus.rsp_err, m_err);
    chk("rsp_timeout", bus.rsp_timeout, m_to);
  end

  // called at a negedge; returns response fields and cycle of rsp_valid
  // counted from the accept edge (zero-wait -> 3)
  task automatic do_cmd(input logic w, input logic [7:0] a,
      input logic [31:0] d, input int wt, input bit poke,
      output logic [31:0] rd, output logic er, output logic tmo,
      output int lat);
    int k;
    bit seen;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", bus.cmd_ready, 1);
    wait_plan = wt;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    seen = 0; rd = 0; er = 0; tmo = 0; lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (poke && i == 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = ~w;
        bus.cmd_addr = 8'hEE;
        bus.cmd_wdata = 32'h5555_AAAA;
      end
      if (poke && i == 1) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) begin
        seen = 1;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        tmo = bus.rsp_timeout;
        lat = i + 2;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("rsp_seen", seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er, tmo;
    int lat;
    int waits[6];
    waits = '{0, 3, 1, 5, 2, 4};
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.PREADY = 1; bus.PSLVERR = 0; bus.PRDATA = 0;
    repeat (3) @(negedge clk);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.cmd_ready, 1);

    do_cmd(1, 8'h04, 32'hA5A5_0001, 0, 0, rd, er, tmo, lat);
    chk("t1_lat", lat, 3);
    chk("t1_err", er, 0);
    chk("t1_rdata", rd, 0);

    do_cmd(1, 8'h00, 32'h0000_00F0, 1, 0, rd, er, tmo, lat);
    do_cmd(1, 8'h04, 32'h0000_0001, 1, 0, rd, er, tmo, lat);
    chk("t2_wlat", lat, 4);
    do_cmd(0, 8'h08, 32'h0, 1, 0, rd, er, tmo, lat);
    chk("t2_res", rd, 32'h0000_00F0);
    chk("t2_err", er, 0);
    do_cmd(0, 8'h04, 32'h0, 1, 0, rd, er, tmo, lat);
    chk("t2_ctrl", rd, 32'h0000_0001);

    do_cmd(1, 8'h08, 32'h0000_1234, 1, 0, rd, er, tmo, lat);
    chk("t3_werr", er, 1);
    chk("t3_wto", tmo, 0);
    do_cmd(0, 8'h0C, 32'h0, 1, 0, rd, er, tmo, lat);
    chk("t3_rerr", er, 1);
    chk("t3_rdata", rd, 0);

    do_cmd(0, 8'h00, 32'h0, 99, 0, rd, er, tmo, lat);
    chk("t4_lat", lat, 18);
    chk("t4_err", er, 1);
    chk("t4_to", tmo, 1);
    chk("t4_rdata", rd, 0);
    chk("t4_psel", bus.PSEL, 0);
    do_cmd(0, 8'h00, 32'h0, 15, 0, rd, er, tmo, lat);
    chk("t4b_lat", lat, 18);
    chk("t4b_to", tmo, 0);
    chk("t4b_err", er, 0);
    chk("t4b_rdata", rd, 32'h0000_00F0);

    for (int i = 0; i < 6; i++) begin
      do_cmd(1, 8'h00, 32'h5A5A_0000 + i, waits[i], 1, rd, er, tmo, lat);
      chk("t5_wlat", lat, 3 + waits[i]);
      do_cmd(0, 8'h00, 32'h0, waits[i], 1, rd, er, tmo, lat);
      chk("t5_rdata", rd, 32'h5A5A_0000 + i);
    end

    wait_plan = 10;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 8'h04;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_in_access", bus.PENABLE, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_psel", bus.PSEL, 0);
    chk("t6_paddr", bus.PADDR, 0);
    chk("t6_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd(0, 8'h00, 32'h0, 1, 0, rd, er, tmo, lat);
    chk("t6_rdata", rd, 32'h5A5A_0005);
    chk("t6_err", er, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
